scpu_control_fsm: RTL and testbench

//  Multi-cycle fetch/decode/execute controller for the 8-bit sCPU; sits upstream of the writeback 4:1 8-bit mux.

---
 rtl/scpu_pkg.sv | 31 +++
 rtl/scpu_decoder.sv | 32 +++
 rtl/scpu_control_fsm.sv | 119 +++++++++++
 tb/tb_scpu_control_fsm.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scpu_pkg.sv
// scpu_pkg: shared opcodes, FSM states, instruction classes, writeback selects and ALU codes for the sCPU controller
package scpu_pkg;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_MOV = 4'h6;
  localparam logic [3:0] OP_LDI = 4'h7;
  localparam logic [3:0] OP_LD  = 4'h8;
  localparam logic [3:0] OP_ST  = 4'h9;
  localparam logic [3:0] OP_IN  = 4'hA;
  localparam logic [3:0] OP_JMP = 4'hB;
  localparam logic [3:0] OP_JZ  = 4'hC;
  localparam logic [3:0] OP_OUT = 4'hD;
  localparam logic [3:0] OP_ILL = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_OPND, S_MEM, S_HALT} state_t;
  typedef enum logic [2:0] {C_NOP, C_ALU, C_OPND, C_LD, C_ST, C_IN, C_OUT, C_HLT} cls_t;
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_IMM = 2'b01;
  localparam logic [1:0] WB_MEM = 2'b10;
  localparam logic [1:0] WB_IN  = 2'b11;
  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_SUB    = 3'd1;
  localparam logic [2:0] ALU_AND    = 3'd2;
  localparam logic [2:0] ALU_OR     = 3'd3;
  localparam logic [2:0] ALU_XOR    = 3'd4;
  localparam logic [2:0] ALU_PASS_B = 3'd5;
endpackage

// File: rtl/scpu_decoder.sv
// scpu_decoder: combinational opcode -> {alu_op, instruction class, illegal}
// i_op: opcode nibble; o_alu_op: ALU code (ADD for non-ALU ops); o_cls: cls_t class; o_illegal: undefined opcode
module scpu_decoder
  import scpu_pkg::*;
(
  input  logic [3:0] i_op,
  output logic [2:0] o_alu_op,
  output logic [2:0] o_cls,
  output logic       o_illegal
);
  always_comb begin
    o_alu_op  = ALU_ADD;
    o_cls     = C_NOP;
    o_illegal = 1'b0;
    case (i_op)
      OP_ADD: begin o_cls = C_ALU; o_alu_op = ALU_ADD; end
      OP_SUB: begin o_cls = C_ALU; o_alu_op = ALU_SUB; end
      OP_AND: begin o_cls = C_ALU; o_alu_op = ALU_AND; end
      OP_OR:  begin o_cls = C_ALU; o_alu_op = ALU_OR; end
      OP_XOR: begin o_cls = C_ALU; o_alu_op = ALU_XOR; end
      OP_MOV: begin o_cls = C_ALU; o_alu_op = ALU_PASS_B; end
      OP_LDI, OP_JMP, OP_JZ: o_cls = C_OPND;
      OP_LD:  o_cls = C_LD;
      OP_ST:  o_cls = C_ST;
      OP_IN:  o_cls = C_IN;
      OP_OUT: o_cls = C_OUT;
      OP_HLT: o_cls = C_HLT;
      OP_ILL: o_illegal = 1'b1;
      default: o_cls = C_NOP;
    endcase
  end
endmodule

// File: rtl/scpu_control_fsm.sv
// scpu_control_fsm: multi-cycle fetch/decode/execute controller owning PC, IR and Z for the 8-bit sCPU
// clk/rst: clock, sync active-high reset; o_imem_addr/i_imem_rdata: instruction fetch (sync read)
// i_alu_zero: ALU zero in EXEC; o_alu_op/o_rd_idx/o_rs_idx: datapath controls; o_reg_we/o_wb_sel/o_imm_out: writeback
// o_dmem_we/o_dmem_re: data memory; o_out_we: output port; o_halted: HALT state; o_illegal: undefined opcode pulse
module scpu_control_fsm
  import scpu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] o_imem_addr,
  input  logic [7:0]      i_imem_rdata,
  input  logic            i_alu_zero,
  output logic [2:0]      o_alu_op,
  output logic [1:0]      o_rd_idx,
  output logic [1:0]      o_rs_idx,
  output logic            o_reg_we,
  output logic [1:0]      o_wb_sel,
  output logic [7:0]      o_imm_out,
  output logic            o_dmem_we,
  output logic            o_dmem_re,
  output logic            o_out_we,
  output logic            o_halted,
  output logic            o_illegal
);
  state_t          r_state, w_nstate;
  logic [7:0]      r_ir, r_imm;
  logic [PC_W-1:0] r_pc, w_pc_inc, w_opnd;
  logic            r_z;
  logic [3:0]      w_op;
  logic [2:0]      w_alu, w_cls;
  logic            w_ill, w_ex, w_ldi, w_opnd_ldi;
  logic            r_reg_we, r_dmem_we, r_dmem_re, r_out_we, r_halted, r_illegal;
  logic [1:0]      r_wb_sel;
  logic [2:0]      r_alu_op;
  // Outputs are registered, so they are decoded from the state/opcode the FSM is about to enter;
  // on the DECODE->EXEC edge the opcode comes straight from the memory byte being latched into IR.
  assign w_op       = r_state == S_DECODE ? i_imem_rdata[7:4] : r_ir[7:4];
  assign w_ex       = w_nstate == S_EXEC;
  assign w_ldi      = w_op == OP_LDI;
  assign w_opnd_ldi = r_state == S_OPND && r_ir[7:4] == OP_LDI;
  assign w_pc_inc   = r_pc + PC_W'(1);
  assign w_opnd     = PC_W'(i_imem_rdata);
  scpu_decoder u_dec (
    .i_op     (w_op),
    .o_alu_op (w_alu),
    .o_cls    (w_cls),
    .o_illegal(w_ill)
  );
  always_comb begin
    w_nstate = S_FETCH;
    case (r_state)
      S_FETCH:  w_nstate = S_DECODE;
      S_DECODE: w_nstate = S_EXEC;
      S_EXEC:   w_nstate = w_cls == C_OPND ? S_OPND : w_cls == C_LD ? S_MEM : w_cls == C_HLT ? S_HALT : S_FETCH;
      S_HALT:   w_nstate = S_HALT;
      default:  w_nstate = S_FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_z       <= 1'b0;
      r_imm     <= '0;
      r_reg_we  <= 1'b0;
      r_wb_sel  <= WB_ALU;
      r_alu_op  <= ALU_ADD;
      r_dmem_we <= 1'b0;
      r_dmem_re <= 1'b0;
      r_out_we  <= 1'b0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      r_reg_we  <= (w_ex && (w_cls == C_ALU || w_cls == C_IN)) || (w_nstate == S_OPND && w_ldi) || w_nstate == S_MEM;
      r_wb_sel  <= w_ex && w_cls == C_IN ? WB_IN : w_nstate == S_OPND && w_ldi ? WB_IMM : w_nstate == S_MEM ? WB_MEM : WB_ALU;
      r_alu_op  <= w_ex ? w_alu : ALU_ADD;
      r_dmem_we <= w_ex && w_cls == C_ST;
      r_dmem_re <= w_ex && w_cls == C_LD;
      r_out_we  <= w_ex && w_cls == C_OUT;
      r_illegal <= w_ex && w_ill;
      r_halted  <= w_nstate == S_HALT;
      if (r_state == S_DECODE) begin
        r_ir <= i_imem_rdata;
        r_pc <= w_pc_inc;
      end
      if (r_state == S_EXEC && w_cls == C_ALU)
        r_z <= i_alu_zero;
      if (r_state == S_OPND) begin
        case (r_ir[7:4])
          OP_LDI: begin
            r_imm <= i_imem_rdata;
            r_pc  <= w_pc_inc;
          end
          OP_JMP: r_pc <= w_opnd;
          OP_JZ:  r_pc <= r_z ? w_opnd : w_pc_inc;
          default: r_pc <= r_pc;
        endcase
      end
    end
  end
  assign o_imem_addr = r_pc;
  assign o_rd_idx    = r_ir[3:2];
  assign o_rs_idx    = r_ir[1:0];
  // LDI writes back in the same cycle the operand arrives, so bypass the operand byte around r_imm.
  assign o_imm_out   = w_opnd_ldi ? i_imem_rdata : r_imm;
  assign o_reg_we    = r_reg_we;
  assign o_wb_sel    = r_wb_sel;
  assign o_alu_op    = r_alu_op;
  assign o_dmem_we   = r_dmem_we;
  assign o_dmem_re   = r_dmem_re;
  assign o_out_we    = r_out_we;
  assign o_halted    = r_halted;
  assign o_illegal   = r_illegal;
endmodule

// File: tb/tb_scpu_control_fsm.sv
// tb_scpu_control_fsm: directed scenarios plus randomized programs checked against an instruction-level model
module tb_scpu_control_fsm;
  logic       clk, rst, alu_zero;
  logic [7:0] imem_rdata, imem_rdata2, imem_addr, imem_addr2;
  logic [7:0] imem [256];
  logic [2:0] alu_op, alu_op2;
  logic [1:0] rd_idx, rs_idx, wb_sel, rd_idx2, rs_idx2, wb_sel2;
  logic [7:0] imm_out, imm_out2;
  logic       reg_we, dmem_we, dmem_re, out_we, halted, illegal;
  logic       reg_we2, dmem_we2, dmem_re2, out_we2, halted2, illegal2;
  int         vectors = 0;
  int         miscompares = 0;

  scpu_control_fsm dut (
    .clk(clk), .rst(rst), .o_imem_addr(imem_addr), .i_imem_rdata(imem_rdata), .i_alu_zero(alu_zero),
    .o_alu_op(alu_op), .o_rd_idx(rd_idx), .o_rs_idx(rs_idx), .o_reg_we(reg_we), .o_wb_sel(wb_sel),
    .o_imm_out(imm_out), .o_dmem_we(dmem_we), .o_dmem_re(dmem_re), .o_out_we(out_we),
    .o_halted(halted), .o_illegal(illegal)
  );

  scpu_control_fsm #(.PC_W(8), .RESET_PC(8'hFF)) dut_wrap (
    .clk(clk), .rst(rst), .o_imem_addr(imem_addr2), .i_imem_rdata(imem_rdata2), .i_alu_zero(alu_zero),
    .o_alu_op(alu_op2), .o_rd_idx(rd_idx2), .o_rs_idx(rs_idx2), .o_reg_we(reg_we2), .o_wb_sel(wb_sel2),
    .o_imm_out(imm_out2), .o_dmem_we(dmem_we2), .o_dmem_re(dmem_re2), .o_out_we(out_we2),
    .o_halted(halted2), .o_illegal(illegal2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    imem_rdata  <= imem[imem_addr];
    imem_rdata2 <= imem[imem_addr2];
  end

  // {reg_we, wb_sel, dmem_we, dmem_re, out_we, halted, illegal}
  function automatic logic [7:0] strobes();
    return {reg_we, wb_sel, dmem_we, dmem_re, out_we, halted, illegal};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;
  endtask

  // Leaves rst low at a negedge with the DUT sitting in its first FETCH cycle.
  task automatic do_reset();
    rst = 1'b1;
    alu_zero = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_imem();
    do_reset();
    vectors++;
    if (strobes() !== 8'h00) begin miscompares++; $display("FAIL reset_strobes: got %h want 00", strobes()); end
    vectors++;
    if (imem_addr !== 8'h00) begin miscompares++; $display("FAIL reset_pc: got %h want 00", imem_addr); end
    vectors++;
    if ({alu_op, imm_out} !== 11'h0) begin miscompares++; $display("FAIL reset_aluop_imm: got %h/%h want 0/00", alu_op, imm_out); end
  endtask

  task automatic test_ldi();
    clear_imem();
    imem[0] = 8'h74;
    imem[1] = 8'h5A;
    do_reset();
    tick();
    tick();
    vectors++;
    if ({imem_addr, strobes()} !== {8'h01, 8'h00}) begin miscompares++; $display("FAIL ldi_exec: got addr %h strb %h want 01/00", imem_addr, strobes()); end
    tick();
    vectors++;
    if ({strobes(), rd_idx, imm_out} !== {8'hA0, 2'd1, 8'h5A}) begin
      miscompares++; $display("FAIL ldi_opnd: got strb %h rd %0d imm %h want a0/1/5a", strobes(), rd_idx, imm_out);
    end
    tick();
    vectors++;
    if ({imem_addr, strobes(), imm_out} !== {8'h02, 8'h00, 8'h5A}) begin
      miscompares++; $display("FAIL ldi_next: got addr %h strb %h imm %h want 02/00/5a", imem_addr, strobes(), imm_out);
    end
  endtask

  task automatic test_add_jz();
    logic zv;
    for (int k = 0; k < 2; k++) begin
      zv = (k == 0);
      clear_imem();
      imem[0] = 8'h10;
      imem[1] = 8'hC0;
      imem[2] = 8'h40;
      do_reset();
      tick();
      tick();
      vectors++;
      if ({strobes(), alu_op} !== {8'h80, 3'd0}) begin miscompares++; $display("FAIL add_exec: got strb %h op %0d want 80/0", strobes(), alu_op); end
      alu_zero = zv;
      tick();
      alu_zero = !zv;
      tick();
      tick();
      vectors++;
      if ({imem_addr, strobes()} !== {8'h02, 8'h00}) begin miscompares++; $display("FAIL jz_exec: got addr %h strb %h want 02/00", imem_addr, strobes()); end
      tick();
      tick();
      vectors++;
      if (imem_addr !== (zv ? 8'h40 : 8'h03)) begin
        miscompares++; $display("FAIL jz_target z=%0d: got %h want %h", zv, imem_addr, zv ? 8'h40 : 8'h03);
      end
    end
  endtask

  task automatic test_ld_st();
    clear_imem();
    imem[0] = 8'h8B;
    imem[1] = 8'h9B;
    do_reset();
    tick();
    tick();
    vectors++;
    if (strobes() !== 8'h08) begin miscompares++; $display("FAIL ld_exec: got %h want 08", strobes()); end
    tick();
    vectors++;
    if ({strobes(), rd_idx, rs_idx} !== {8'hC0, 2'd2, 2'd3}) begin
      miscompares++; $display("FAIL ld_mem: got strb %h rd %0d rs %0d want c0/2/3", strobes(), rd_idx, rs_idx);
    end
    tick();
    vectors++;
    if ({imem_addr, strobes()} !== {8'h01, 8'h00}) begin miscompares++; $display("FAIL ld_next: got addr %h strb %h want 01/00", imem_addr, strobes()); end
    tick();
    tick();
    vectors++;
    if (strobes() !== 8'h10) begin miscompares++; $display("FAIL st_exec: got %h want 10", strobes()); end
    tick();
    vectors++;
    if ({imem_addr, strobes()} !== {8'h02, 8'h00}) begin miscompares++; $display("FAIL st_next: got addr %h strb %h want 02/00", imem_addr, strobes()); end
  endtask

  task automatic test_pc_wrap();
    clear_imem();
    do_reset();
    vectors++;
    if (imem_addr2 !== 8'hFF) begin miscompares++; $display("FAIL wrap_reset_pc: got %h want ff", imem_addr2); end
    tick();
    tick();
    tick();
    vectors++;
    if (imem_addr2 !== 8'h00) begin miscompares++; $display("FAIL wrap_next: got %h want 00", imem_addr2); end
  endtask

  task automatic test_illegal_halt();
    clear_imem();
    imem[0] = 8'hE0;
    imem[1] = 8'hF0;
    do_reset();
    tick();
    tick();
    vectors++;
    if (strobes() !== 8'h01) begin miscompares++; $display("FAIL illegal_pulse: got %h want 01", strobes()); end
    tick();
    vectors++;
    if ({imem_addr, strobes()} !== {8'h01, 8'h00}) begin miscompares++; $display("FAIL illegal_next: got addr %h strb %h want 01/00", imem_addr, strobes()); end
    tick();
    tick();
    tick();
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if ({imem_addr, strobes()} !== {8'h02, 8'h02}) begin
        miscompares++; $display("FAIL halt_hold[%0d]: got addr %h strb %h want 02/02", i, imem_addr, strobes());
      end
      alu_zero = 1'($urandom_range(0, 1));
      tick();
    end
    rst = 1'b1;
    tick();
    vectors++;
    if ({imem_addr, strobes()} !== {8'h00, 8'h00}) begin miscompares++; $display("FAIL halt_reset: got addr %h strb %h want 00/00", imem_addr, strobes()); end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    clear_imem();
    imem[0] = 8'hB0;
    imem[1] = 8'h20;
    do_reset();
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    vectors++;
    if ({imem_addr, strobes()} !== {8'h00, 8'h00}) begin miscompares++; $display("FAIL midreset: got addr %h strb %h want 00/00", imem_addr, strobes()); end
    rst = 1'b0;
    tick();
    tick();
    vectors++;
    if (imem_addr !== 8'h01) begin miscompares++; $display("FAIL midreset_refetch: got %h want 01", imem_addr); end
    tick();
    tick();
    vectors++;
    if (imem_addr !== 8'h20) begin miscompares++; $display("FAIL jmp_target: got %h want 20", imem_addr); end
  endtask

  // Instruction-level model: each instruction is FETCH, DECODE, EXEC plus an optional fourth
  // cycle, with the architectural effects applied once the instruction completes.
  task automatic test_random();
    logic [7:0] b, m_pc, a1, opnd, ir;
    logic [3:0] op;
    logic       m_z, zs, e_we, e_dwe, e_dre, e_owe, e_ill, is_alu;
    logic [1:0] e_wb;
    int         len;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      if (b[7:4] == 4'hF) b[7:4] = 4'h0;
      imem[i] = b;
    end
    do_reset();
    m_pc = 8'h00;
    m_z  = 1'b0;
    for (int n = 0; n < 200; n++) begin
      ir     = imem[m_pc];
      op     = ir[7:4];
      a1     = m_pc + 8'd1;
      opnd   = imem[a1];
      is_alu = op >= 4'd1 && op <= 4'd6;
      len    = (op == 4'h7 || op == 4'h8 || op == 4'hB || op == 4'hC) ? 4 : 3;
      for (int c = 0; c < len; c++) begin
        e_we  = (c == 2 && (is_alu || op == 4'hA)) || (c == 3 && (op == 4'h7 || op == 4'h8));
        e_wb  = (c == 2 && op == 4'hA) ? 2'b11 : (c == 3 && op == 4'h7) ? 2'b01 : (c == 3 && op == 4'h8) ? 2'b10 : 2'b00;
        e_dwe = c == 2 && op == 4'h9;
        e_dre = c == 2 && op == 4'h8;
        e_owe = c == 2 && op == 4'hD;
        e_ill = c == 2 && op == 4'hE;
        vectors++;
        if (strobes() !== {e_we, e_wb, e_dwe, e_dre, e_owe, 1'b0, e_ill}) begin
          miscompares++;
          $display("FAIL rand_strobes i%0d ir %h c%0d: got %h want %h", n, ir, c, strobes(), {e_we, e_wb, e_dwe, e_dre, e_owe, 1'b0, e_ill});
        end
        if (c == 0 || (c == 2 && len == 4 && op != 4'h8)) begin
          vectors++;
          if (imem_addr !== (c == 0 ? m_pc : a1)) begin
            miscompares++; $display("FAIL rand_addr i%0d ir %h c%0d: got %h want %h", n, ir, c, imem_addr, c == 0 ? m_pc : a1);
          end
        end
        if (c >= 2) begin
          vectors++;
          if ({rd_idx, rs_idx} !== ir[3:0]) begin miscompares++; $display("FAIL rand_idx i%0d: got %h want %h", n, {rd_idx, rs_idx}, ir[3:0]); end
        end
        if (c == 2 && is_alu) begin
          vectors++;
          if (alu_op !== 3'(op - 4'd1)) begin miscompares++; $display("FAIL rand_aluop i%0d: got %0d want %0d", n, alu_op, op - 4'd1); end
        end
        if (c == 3 && op == 4'h7) begin
          vectors++;
          if (imm_out !== opnd) begin miscompares++; $display("FAIL rand_imm i%0d: got %h want %h", n, imm_out, opnd); end
        end
        zs = 1'($urandom_range(0, 1));
        alu_zero = zs;
        if (c == 2 && is_alu) m_z = zs;
        tick();
      end
      case (op)
        4'h7:    m_pc = m_pc + 8'd2;
        4'hB:    m_pc = opnd;
        4'hC:    m_pc = m_z ? opnd : m_pc + 8'd2;
        default: m_pc = a1;
      endcase
    end
  endtask

  initial begin
    rst = 1'b1;
    alu_zero = 1'b0;
    clear_imem();
    test_reset();
    test_ldi();
    test_add_jz();
    test_ld_st();
    test_pc_wrap();
    test_illegal_halt();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
